emb_ram_resp: RTL

EMB_RAM_RESP -- requirements
Module: emb_ram_resp

---
 rtl/emb_ram_resp.sv | 127 ++++++++++++
 1 files changed

// File: rtl/emb_ram_resp.sv
// emb_ram_resp: single-port-per-direction 32-bit word RAM with registered read
// data, access exception pulse and a post-reset zero-clear sweep.
// Optional feature macro: RAM_FWD_EN selects write-first forwarding for a
// same-word read and write in one cycle (read-first when undefined).
module emb_ram_resp #(
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter logic [31:0] BASE       = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] r_addr,
   input  logic        read,
   output logic [31:0] r_line,
   input  logic [31:0] w_addr,
   input  logic [31:0] w_line,
   input  logic        write,
   output logic        exc,
   output logic        busy
);

   localparam int unsigned WORDS = 1 << DEPTH_LOG2;
   localparam logic [32:0] LIMIT = 33'(WORDS) << 2;
   localparam logic [DEPTH_LOG2-1:0] CNT_MAX = '1;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_IDLE = 1'b1
   } state_t;

   logic [31:0]           r_mem [WORDS];
   state_t                r_state;
   logic [DEPTH_LOG2-1:0] r_cnt;

   state_t                w_state_nxt;
   logic [DEPTH_LOG2-1:0] w_cnt_nxt;
   logic                  w_exc_nxt;
   logic [31:0]           w_rdata_nxt;
   logic                  w_we;
   logic [DEPTH_LOG2-1:0] w_widx;
   logic [31:0]           w_wdata;

   logic [31:0]           w_r_off;
   logic [31:0]           w_w_off;
   logic                  w_r_ok;
   logic                  w_w_ok;
   logic [DEPTH_LOG2-1:0] w_r_idx;
   logic [DEPTH_LOG2-1:0] w_w_idx;
   logic [31:0]           w_rd_word;

   // Address decode: 32-bit wrapping offset from BASE, aligned and in range.
   always_comb begin
      w_r_off = r_addr - BASE;
      w_w_off = w_addr - BASE;
      w_r_ok  = (r_addr[1:0] == 2'b00) && ({1'b0, w_r_off} < LIMIT);
      w_w_ok  = (w_addr[1:0] == 2'b00) && ({1'b0, w_w_off} < LIMIT);
      w_r_idx = w_r_off[DEPTH_LOG2+1:2];
      w_w_idx = w_w_off[DEPTH_LOG2+1:2];
   end

   // Read word selection, with optional same-word write-first forwarding.
   always_comb begin
`ifdef RAM_FWD_EN
      w_rd_word = (write && w_w_ok && (w_w_idx == w_r_idx)) ? w_line : r_mem[w_r_idx];
`else
      w_rd_word = r_mem[w_r_idx];
`endif
   end

   // Next-state, sweep counter, write port and registered output values.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_exc_nxt   = 1'b0;
      w_rdata_nxt = r_line;
      w_we        = 1'b0;
      w_widx      = w_w_idx;
      w_wdata     = w_line;
      case (r_state)
         ST_INIT: begin
            w_we        = 1'b1;
            w_widx      = r_cnt;
            w_wdata     = 32'h0;
            w_cnt_nxt   = r_cnt + DEPTH_LOG2'(1);
            w_exc_nxt   = read | write;
            w_rdata_nxt = 32'h0;
            if (r_cnt == CNT_MAX) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_IDLE: begin
            w_we      = write & w_w_ok;
            w_exc_nxt = (read & ~w_r_ok) | (write & ~w_w_ok);
            if (read) begin
               w_rdata_nxt = w_r_ok ? w_rd_word : 32'h0;
            end
         end
         default: begin
            w_state_nxt = ST_INIT;
         end
      endcase
   end

   // State, counter and output registers; reset restarts the sweep.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_INIT;
         r_cnt   <= '0;
         r_line  <= 32'h0;
         exc     <= 1'b0;
         busy    <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_line  <= w_rdata_nxt;
         exc     <= w_exc_nxt;
         busy    <= (w_state_nxt == ST_INIT);
      end
   end

   // Storage array: sweep clears or external legal write.
   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[w_widx] <= w_wdata;
      end
   end

endmodule
